// File: rtl/fpu_pkg.sv
// Shared widths, opcodes, result-byte layout and FSM encoding for the FP compare unit.
package fpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned MAG_W  = EXP_W + MAN_W;

    // Compare opcodes; anything above OP_LE is illegal
    localparam logic [OP_W-1:0] OP_EQ = 3'd0;
    localparam logic [OP_W-1:0] OP_LT = 3'd1;
    localparam logic [OP_W-1:0] OP_LE = 3'd2;

    // Result-byte bit positions
    localparam int unsigned RES_CMP_BIT     = 0;
    localparam int unsigned RES_UNORD_BIT   = 1;
    localparam int unsigned RES_ILLEGAL_BIT = 7;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } fcmp_state_e;

    // Captured operand set handed to the comparator
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } fcmp_req_t;

endpackage

// File: rtl/fcmp_core.sv
// Combinational single-precision compare with denormal flush, NaN detection and opcode decode.
module fcmp_core
    import fpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [RES_W-1:0]  result
);

    logic              nan_a;
    logic              nan_b;
    logic              unord;
    logic [MAG_W-1:0]  mag_a;
    logic [MAG_W-1:0]  mag_b;
    logic signed [DATA_W-1:0] key_a;
    logic signed [DATA_W-1:0] key_b;
    logic              eq;
    logic              lt;

    // Map each operand to a signed key whose integer order matches float order
    always_comb begin
        nan_a = (&a[DATA_W-2 -: EXP_W]) && (|a[MAN_W-1:0]);
        nan_b = (&b[DATA_W-2 -: EXP_W]) && (|b[MAN_W-1:0]);
        unord = nan_a || nan_b;

        // Exponent zero flushes to zero; magnitude 0 makes +0/-0 identical keys
        mag_a = (a[DATA_W-2 -: EXP_W] == '0) ? '0 : a[MAG_W-1:0];
        mag_b = (b[DATA_W-2 -: EXP_W] == '0) ? '0 : b[MAG_W-1:0];

        key_a = a[DATA_W-1] ? -$signed({1'b0, mag_a}) : $signed({1'b0, mag_a});
        key_b = b[DATA_W-1] ? -$signed({1'b0, mag_b}) : $signed({1'b0, mag_b});

        eq = (key_a == key_b);
        lt = (key_a < key_b);
    end

    // Assemble result byte
    always_comb begin
        result                = '0;
        result[RES_UNORD_BIT] = unord;
        if (op > OP_LE) begin
            result[RES_ILLEGAL_BIT] = 1'b1;
        end else if (!unord) begin
            case (op)
                OP_EQ:   result[RES_CMP_BIT] = eq;
                OP_LT:   result[RES_CMP_BIT] = lt;
                OP_LE:   result[RES_CMP_BIT] = lt || eq;
                default: result[RES_CMP_BIT] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/fcmp_unit.sv
// Three-channel operand collector feeding fcmp_core, with a one-cycle result strobe.
module fcmp_unit
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] in_a,
    input  logic              in_valid_a,
    output logic              in_ready_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_valid_b,
    output logic              in_ready_b,
    input  logic [OP_W-1:0]   in_op,
    input  logic              in_valid_op,
    output logic              in_ready_op,
    output logic [RES_W-1:0]  fcmp_out,
    output logic              fcmp_out_valid
);

    fcmp_state_e      state_q;
    fcmp_state_e      state_d;
    fcmp_req_t        req_q;
    fcmp_req_t        req_d;
    logic             full_a_q;
    logic             full_b_q;
    logic             full_op_q;
    logic             full_a_d;
    logic             full_b_d;
    logic             full_op_d;
    logic             ready_a_d;
    logic             ready_b_d;
    logic             ready_op_d;
    logic [RES_W-1:0] out_d;
    logic             out_valid_d;
    logic [RES_W-1:0] cmp_result_c;

    fcmp_core u_core (
        .a      (req_q.a),
        .b      (req_q.b),
        .op     (req_q.op),
        .result (cmp_result_c)
    );

    // Next-state, capture and output decode
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        full_a_d    = full_a_q;
        full_b_d    = full_b_q;
        full_op_d   = full_op_q;
        out_d       = fcmp_out;
        out_valid_d = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (in_valid_a && in_ready_a) begin
                    req_d.a  = in_a;
                    full_a_d = 1'b1;
                end
                if (in_valid_b && in_ready_b) begin
                    req_d.b  = in_b;
                    full_b_d = 1'b1;
                end
                if (in_valid_op && in_ready_op) begin
                    req_d.op  = in_op;
                    full_op_d = 1'b1;
                end
                if (full_a_d && full_b_d && full_op_d) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                out_d       = cmp_result_c;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                full_a_d  = 1'b0;
                full_b_d  = 1'b0;
                full_op_d = 1'b0;
                state_d   = ST_COLLECT;
            end
            default: begin
                full_a_d  = 1'b0;
                full_b_d  = 1'b0;
                full_op_d = 1'b0;
                state_d   = ST_COLLECT;
            end
        endcase

        // Readies are registered: open only in COLLECT for empty slots
        ready_a_d  = (state_d == ST_COLLECT) && !full_a_d;
        ready_b_d  = (state_d == ST_COLLECT) && !full_b_d;
        ready_op_d = (state_d == ST_COLLECT) && !full_op_d;
    end

    // State, capture and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_COLLECT;
            req_q          <= '0;
            full_a_q       <= 1'b0;
            full_b_q       <= 1'b0;
            full_op_q      <= 1'b0;
            in_ready_a     <= 1'b1;
            in_ready_b     <= 1'b1;
            in_ready_op    <= 1'b1;
            fcmp_out       <= '0;
            fcmp_out_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            full_a_q       <= full_a_d;
            full_b_q       <= full_b_d;
            full_op_q      <= full_op_d;
            in_ready_a     <= ready_a_d;
            in_ready_b     <= ready_b_d;
            in_ready_op    <= ready_op_d;
            fcmp_out       <= out_d;
            fcmp_out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fcmp_unit.sv
// Self-checking bench for fcmp_unit: directed table, staggered handshake, reset abort, random vs real-valued model.
module tb_fcmp_unit;

    logic        clk;
    logic        rstn;
    logic [31:0] in_a;
    logic        in_valid_a;
    logic        in_ready_a;
    logic [31:0] in_b;
    logic        in_valid_b;
    logic        in_ready_b;
    logic [2:0]  in_op;
    logic        in_valid_op;
    logic        in_ready_op;
    logic [7:0]  fcmp_out;
    logic        fcmp_out_valid;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[14];

    fcmp_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_a           (in_a),
        .in_valid_a     (in_valid_a),
        .in_ready_a     (in_ready_a),
        .in_b           (in_b),
        .in_valid_b     (in_valid_b),
        .in_ready_b     (in_ready_b),
        .in_op          (in_op),
        .in_valid_op    (in_valid_op),
        .in_ready_op    (in_ready_op),
        .fcmp_out       (fcmp_out),
        .fcmp_out_valid (fcmp_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Real value of a single-precision pattern; exponent 0 is zero, infinity is a huge real
    function automatic real to_real(input logic [31:0] x);
        int  e;
        real mag;
        e = int'(x[30:23]);
        if (e == 0) return 0.0;
        if (e == 255) mag = 1.0e300;
        else mag = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic [7:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [7:0] r;
        logic       nan;
        real        ra;
        real        rb;
        nan = (a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0);
        ra  = to_real(a);
        rb  = to_real(b);
        r   = 8'h00;
        r[1] = nan;
        if (op > 3'd2) r[7] = 1'b1;
        else if (!nan) begin
            if (op == 3'd0) r[0] = (ra == rb);
            if (op == 3'd1) r[0] = (ra < rb);
            if (op == 3'd2) r[0] = (ra <= rb);
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_operand(input logic [31:0] other);
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 7))
            0: x[30:23] = 8'h00;
            1: begin x[30:23] = 8'hFF; x[22] = 1'b1; end
            2: begin x[30:23] = 8'hFF; x[22:0] = 23'h0; end
            3: x = other;
            4: x = {~other[31], other[30:0]};
            default: x[30:23] = 8'(120 + $urandom_range(0, 15));
        endcase
        return x;
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(in_ready_a && in_ready_b && in_ready_op) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_wait"}, {29'h0, in_ready_a, in_ready_b, in_ready_op}, 32'h7);
    endtask

    // Present all three channels on one cycle and check strobe timing and value
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [7:0] exp, input string name);
        wait_ready(name);
        in_a = a; in_b = b; in_op = op;
        in_valid_a = 1'b1; in_valid_b = 1'b1; in_valid_op = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_op = 1'b0;
        check({name, "_cap"}, {28'h0, fcmp_out_valid, in_ready_a, in_ready_b, in_ready_op}, 32'h0);
        @(posedge clk); #1;
        check({name, "_strobe"}, {23'h0, fcmp_out_valid, fcmp_out}, {23'h0, 1'b1, exp});
        @(posedge clk); #1;
        check({name, "_done"}, {20'h0, fcmp_out_valid, in_ready_a, in_ready_b, in_ready_op, fcmp_out},
              {20'h0, 1'b0, 3'b111, exp});
    endtask

    initial begin
        int          strobe_cnt;
        int          strobe_edge;
        logic [7:0]  strobe_val;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;

        checks = 0;
        errors = 0;
        rstn = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_op = 1'b0;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 3'd1, 8'h01};
        vecs[1]  = '{32'h80000000, 32'h00000000, 3'd0, 8'h01};
        vecs[2]  = '{32'h00000001, 32'h80000000, 3'd0, 8'h01};
        vecs[3]  = '{32'h7FC00000, 32'h3F800000, 3'd2, 8'h02};
        vecs[4]  = '{32'h00000000, 32'h00000000, 3'd5, 8'h80};
        vecs[5]  = '{32'hC0000000, 32'hBF800000, 3'd1, 8'h01};
        vecs[6]  = '{32'hBF800000, 32'hC0000000, 3'd1, 8'h00};
        vecs[7]  = '{32'h3F800000, 32'h3F800000, 3'd2, 8'h01};
        vecs[8]  = '{32'h3F800000, 32'h3F800000, 3'd1, 8'h00};
        vecs[9]  = '{32'h7F800000, 32'h7F7FFFFF, 3'd1, 8'h00};
        vecs[10] = '{32'hFF800000, 32'h7F800000, 3'd1, 8'h01};
        vecs[11] = '{32'h7FC00000, 32'h00000000, 3'd6, 8'h82};
        vecs[12] = '{32'h80800000, 32'h00800000, 3'd0, 8'h00};
        vecs[13] = '{32'h7F800001, 32'h7F800001, 3'd0, 8'h02};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {20'h0, fcmp_out_valid, in_ready_a, in_ready_b, in_ready_op, fcmp_out},
              {20'h0, 1'b0, 3'b111, 8'h00});
        @(negedge clk);
        rstn = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Staggered channels, each valid held two cycles; a's data changes while still valid
        wait_ready("stag");
        strobe_cnt  = 0;
        strobe_edge = -1;
        strobe_val  = 8'h00;
        for (int t = 0; t < 10; t++) begin
            if (t > 0) @(negedge clk);
            in_valid_a  = (t < 2);
            in_a        = (t == 0) ? 32'h3F800000 : 32'h40400000;
            in_valid_op = (t == 3 || t == 4);
            in_op       = 3'd1;
            in_valid_b  = (t == 5 || t == 6);
            in_b        = 32'h40000000;
            @(posedge clk); #1;
            if (t == 0) check("stag_a_taken", {31'h0, in_ready_a}, 32'h0);
            if (t == 3) check("stag_op_taken", {30'h0, in_ready_op, in_ready_b}, 32'h1);
            if (fcmp_out_valid) begin
                strobe_cnt++;
                strobe_edge = t;
                strobe_val  = fcmp_out;
            end
        end
        check("stag_strobe_count", 32'(strobe_cnt), 32'd1);
        check("stag_strobe_edge", 32'(strobe_edge), 32'd6);
        check("stag_result", {24'h0, strobe_val}, 32'h01);

        // Reset while in COMPARE
        wait_ready("rst");
        in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 3'd1;
        in_valid_a = 1'b1; in_valid_b = 1'b1; in_valid_op = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_op = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_abort", {20'h0, fcmp_out_valid, in_ready_a, in_ready_b, in_ready_op, fcmp_out},
              {20'h0, 1'b0, 3'b111, 8'h00});
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("rst_no_strobe", {31'h0, fcmp_out_valid}, 32'h0);
        end
        @(negedge clk);
        rstn = 1'b1;
        run_op(32'hC0000000, 32'hBF800000, 3'd1, 8'h01, "post_rst");

        // Random operands against the real-valued model
        for (int n = 0; n < 150; n++) begin
            ra  = rand_operand($urandom);
            rb  = rand_operand(ra);
            rop = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            run_op(ra, rb, rop, model(ra, rb, rop), $sformatf("rand%0d_%h_%h_%0d", n, ra, rb, rop));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
